// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader: section widths,
// section offsets within the flat configuration bus, and the loader state enum.
package fpga_cfg_pkg;

    // Section widths in bits.
    localparam int BRB_BITS = 900;
    localparam int BSB_BITS = 1728;
    localparam int LB_BITS  = 80;
    localparam int IO_BITS  = 30;

    // Offsets within cfg_out, packed LSB-first.
    localparam int BRB_OFF       = 0;
    localparam int BSB_OFF       = BRB_OFF + BRB_BITS;
    localparam int LB_OFF        = BSB_OFF + BSB_BITS;
    localparam int IO_LEFT_OFF   = LB_OFF + LB_BITS;
    localparam int IO_RIGHT_OFF  = IO_LEFT_OFF + IO_BITS;
    localparam int IO_TOP_OFF    = IO_RIGHT_OFF + IO_BITS;
    localparam int IO_BOTTOM_OFF = IO_TOP_OFF + IO_BITS;

    // Total configuration width (2828 for the full fabric).
    localparam int CFG_BITS = IO_BOTTOM_OFF + IO_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/fpga_config_loader.sv
// Byte-serial configuration loader. Bytes arrive over a valid/ready stream
// and are assembled LSB-first into a shadow register; an XOR checksum trailer
// guards the load, and only a matching trailer commits the shadow to cfg_out.
// A failed or aborted load leaves the previously committed configuration live.
module fpga_config_loader #(
    parameter int CFG_BITS = fpga_cfg_pkg::CFG_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [CFG_BITS-1:0] cfg_out,
    output logic                cfg_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);
    import fpga_cfg_pkg::*;

    localparam int NBYTES = (CFG_BITS + 7) / 8;
    localparam int CW     = $clog2(NBYTES + 1);

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [7:0]          csum;
    logic [CFG_BITS-1:0] shadow;
    logic                accept;

    // Ready only while collecting payload or trailer; abort masks it so an
    // aborting cycle never consumes a byte.
    assign in_ready = ((state == LOAD) || (state == CHECK)) && !abort;
    assign accept   = in_valid && in_ready;

    // Shadow write: byte k lands at bits [8k+7:8k]; bits past CFG_BITS in the
    // final byte simply have no destination flop.
    for (genvar j = 0; j < CFG_BITS; j++) begin : g_shadow
        // NOTE: the shadow is a pure data store that is always fully rewritten
        // before it is committed, so it carries no reset.
        always_ff @(posedge clk) begin
            if ((state == LOAD) && accept && (cnt == CW'(j / 8))) begin
                shadow[j] <= in_data[j % 8];
            end
        end
    end

    // Load sequencer with registered status outputs and commit of the shadow.
    always_ff @(posedge clk) begin
        // NOTE: every register here uses non-blocking assignment so all
        // updates in a cycle see the pre-edge values of state, cnt and csum.
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            csum      <= '0;
            cfg_out   <= '0;
            cfg_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        csum  <= '0;
                        err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        csum <= csum ^ in_data;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(NBYTES - 1)) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        if (in_data == csum) begin
                            state <= COMMIT;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    cfg_out   <= shadow;
                    cfg_valid <= 1'b1;
                    done      <= 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Self-checking bench for fpga_config_loader at CFG_BITS=20 (3 payload bytes).
// A transaction-level model (queue of accepted bytes, XOR of the queue, image
// assembled by shifting) predicts every output each cycle; directed loads
// pin the model with hand-computed values, then randomized traffic runs.
module tb_fpga_config_loader;

    localparam int CB = 20;
    localparam int NB = (CB + 7) / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CB-1:0] cfg_out;
    logic          cfg_valid;
    logic          busy;
    logic          done;
    logic          err;

    fpga_config_loader #(.CFG_BITS(CB)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cfg_out  (cfg_out),
        .cfg_valid(cfg_valid),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            m_active;   // a load is collecting bytes
    bit            m_commit;   // a verified image is about to go live
    bit            m_cfg_valid;
    bit            m_err;
    bit            m_done;
    bit            chk_en = 1'b0;
    logic [7:0]    m_bytes[$];
    logic [CB-1:0] m_cfg;
    logic [CB-1:0] m_pending;

    function automatic logic [7:0] m_sum();
        logic [7:0] s = 8'h00;
        foreach (m_bytes[k]) s = s ^ m_bytes[k];
        return s;
    endfunction

    function automatic logic [CB-1:0] m_image();
        logic [8*NB-1:0] full = '0;
        foreach (m_bytes[k]) full = full | ({{(8*NB-8){1'b0}}, m_bytes[k]} << (8 * k));
        return full[CB-1:0];
    endfunction

    task automatic model_step();
        if (rst) begin
            m_active    = 1'b0;
            m_commit    = 1'b0;
            m_cfg       = '0;
            m_cfg_valid = 1'b0;
            m_err       = 1'b0;
            m_done      = 1'b0;
            m_bytes.delete();
            chk_en      = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_commit) begin
                m_cfg       = m_pending;
                m_cfg_valid = 1'b1;
                m_done      = 1'b1;
                m_commit    = 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_bytes.delete();
                    m_err = 1'b0;
                end
            end else if (abort) begin
                m_active = 1'b0;
            end else if (in_valid) begin
                if (m_bytes.size() < NB) begin
                    m_bytes.push_back(in_data);
                end else begin
                    if (in_data == m_sum()) begin
                        m_commit  = 1'b1;
                        m_pending = m_image();
                    end else begin
                        m_err = 1'b1;
                    end
                    m_active = 1'b0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("in_ready",  32'(in_ready),  32'(m_active && !abort));
            check("busy",      32'(busy),      32'(m_active || m_commit));
            check("done",      32'(done),      32'(m_done));
            check("err",       32'(err),       32'(m_err));
            check("cfg_valid", 32'(cfg_valid), 32'(m_cfg_valid));
            check("cfg_out",   32'(cfg_out),   32'(m_cfg));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    // Offer one byte after 'gap' idle cycles; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc = 1'b0;
        in_valid = 1'b0;
        idle(gap);
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            next_cycle();
        end
        in_valid = 1'b0;
        check("byte_accept", 32'(acc), 32'(1'b1));
    endtask

    task automatic send_load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] trl, input int gap);
        send_byte(b0, gap);
        send_byte(b1, gap);
        send_byte(b2, gap);
        send_byte(trl, gap);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle(2);
        rst = 1'b0;
        check("rst_cfg_out",   32'(cfg_out),   32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_cfg_valid", 32'(cfg_valid), 32'h0);

        // Bad checksum on the very first load.
        pulse_start();
        send_load(8'hA5, 8'h3C, 8'h0F, 8'h00, 0);
        idle(2);
        check("bad_err",       32'(err),       32'h1);
        check("bad_cfg_valid", 32'(cfg_valid), 32'h0);
        check("bad_cfg_out",   32'(cfg_out),   32'h0);

        // Nominal load: done and cfg_out appear two cycles after the trailer.
        pulse_start();
        check("start_clears_err", 32'(err), 32'h0);
        send_load(8'hA5, 8'h3C, 8'h0F, 8'h96, 0);
        check("nom_done_n1",  32'(done),    32'h0);
        check("nom_old_cfg",  32'(cfg_out), 32'h0);
        next_cycle();
        check("nom_done_n2",   32'(done),      32'h1);
        check("nom_cfg_out",   32'(cfg_out),   32'hF3CA5);
        check("nom_cfg_valid", 32'(cfg_valid), 32'h1);
        check("nom_err",       32'(err),       32'h0);
        next_cycle();
        check("nom_done_once", 32'(done), 32'h0);

        // Abort after two bytes with a byte on offer.
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(negedge clk);
        check("abort_in_ready", 32'(in_ready), 32'h0);
        next_cycle();
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", 32'(busy),    32'h0);
        check("abort_cfg",  32'(cfg_out), 32'hF3CA5);

        // Backpressure: in_valid toggles every other cycle.
        pulse_start();
        send_load(8'hA5, 8'h3C, 8'h0F, 8'h96, 1);
        idle(2);
        check("bp_cfg_out", 32'(cfg_out), 32'hF3CA5);

        // Reload with a stray start mid-load; old config stays until commit.
        pulse_start();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        pulse_start();
        send_byte(8'h03, 0);
        check("reload_old_cfg", 32'(cfg_out), 32'hF3CA5);
        send_byte(8'h30, 0);
        check("reload_busy", 32'(busy), 32'h1);
        next_cycle();
        check("reload_cfg_out", 32'(cfg_out), 32'h32211);

        // Reset in the middle of a load.
        pulse_start();
        send_byte(8'h55, 0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("mid_rst_cfg_out",   32'(cfg_out),   32'h0);
        check("mid_rst_cfg_valid", 32'(cfg_valid), 32'h0);
        check("mid_rst_in_ready",  32'(in_ready),  32'h0);
        check("mid_rst_busy",      32'(busy),      32'h0);

        // Padding bits of the last byte are dropped from the image.
        pulse_start();
        send_load(8'h00, 8'h00, 8'hFF, 8'hFF, 0);
        idle(2);
        check("pad_cfg_out", 32'(cfg_out), 32'hF0000);

        // Randomized traffic; trailers are usually correct so commits happen.
        for (int c = 0; c < 4000; c++) begin
            start    = ($urandom_range(0, 7) == 0);
            abort    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            rst      = ($urandom_range(0, 999) == 0);
            if (m_active && m_bytes.size() == NB && $urandom_range(0, 3) != 0)
                in_data = m_sum();
            else
                in_data = 8'($urandom);
            next_cycle();
        end
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        rst      = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpga_config_loader.md
Name: fpga_config_loader

Overview:
- Upstream configuration stage for the FPGA fabric top.
- Accepts a byte-serial bitstream over a valid/ready stream and assembles it into a shadow register.
- Verifies an XOR checksum trailer, then commits atomically to the flat configuration bus.
- The top level slices that bus into brbselect, bsbselect, lbselect and the four io select buses.
- Until a commit, the fabric keeps running on the old configuration.

Parameters:
- CFG_BITS, 2828: total configuration bits (900 brb + 1728 bsb + 80 lb + 4x30 io).
- NBYTES, (CFG_BITS+7)/8: payload bytes per load. Derived; do not override.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that begins a load. Ignored unless in IDLE.
- abort, input, 1: cancels an in-progress load.
- in_data, input, 8: bitstream byte.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: loader accepts a byte this cycle.
- cfg_out, output, CFG_BITS: committed configuration bus.
- cfg_valid, output, 1: at least one successful commit since reset.
- busy, output, 1: load in progress.
- done, output, 1: one-cycle pulse on commit.
- err, output, 1: checksum mismatch. Sticky.

Behaviour:
- Reset (rst=1 at an edge) forces:
  - state=IDLE;
  - cfg_out=0, cfg_valid=0, busy=0, done=0, err=0, in_ready=0;
  - byte counter=0, running checksum=0.
  - Shadow register contents are don't-care.
- Reset mid-load discards the partial load; cfg_out returns to 0.
- A byte is accepted only on a cycle where in_valid && in_ready.
- in_ready is combinational from state: 1 in LOAD and CHECK, else 0. It does not depend on in_valid.
- States:
  - IDLE: busy=0. start → LOAD; at the same edge clear the counter and checksum, and clear err.
  - LOAD: busy=1. Accepted byte k is written to shadow[8k+7:8k], and checksum ^= byte.
    - Bits of the last byte at positions >= CFG_BITS are dropped from the shadow but still enter the checksum.
    - On accepting byte NBYTES-1 → CHECK.
  - CHECK: busy=1. The accepted byte is the trailer.
    - If trailer == checksum → COMMIT.
    - Otherwise → IDLE with err=1; cfg_out and cfg_valid are unchanged.
  - COMMIT: busy=1, in_ready=0. At this edge: cfg_out <= shadow, cfg_valid <= 1, done=1 for the following cycle; → IDLE.
- Latency: trailer accepted in cycle N → new cfg_out and done visible in cycle N+2.
- abort in LOAD or CHECK → IDLE at that edge.
  - Any byte presented that cycle is not accepted (abort wins; in_ready is forced 0).
  - err is unchanged and cfg_out is untouched.
- abort in IDLE or COMMIT has no effect. A commit cannot be aborted.
- start while not in IDLE is ignored.
- start and abort together in IDLE → LOAD.
- in_valid gaps in LOAD or CHECK: state and counter hold indefinitely.
- cfg_valid never falls except on reset. Reload failures leave the prior configuration in force.
- Counter width: $clog2(NBYTES+1). Counter never wraps; the state change precedes overflow.

Decomposition:
- Shared package fpga_cfg_pkg holds:
  - section widths: BRB_BITS=900, BSB_BITS=1728, LB_BITS=80, IO_BITS=30;
  - offsets within cfg_out, packed LSB-first in this order: brb, bsb, lb, left io, right io, top io, bottom io;
  - CFG_BITS, derived from the above;
  - state enum IDLE/LOAD/CHECK/COMMIT.
- No sub-module. Shadow write and checksum stay inline.

Test Plan:
- Nominal load (CFG_BITS=20, NBYTES=3): start; bytes 0xA5, 0x3C, 0x0F, trailer 0x96 → done pulses at N+2, cfg_out=20'hF3CA5, cfg_valid=1, err=0.
- Bad checksum: same bytes, trailer 0x00 → err=1, no done, cfg_out=0, cfg_valid=0. A following correct load clears err and commits.
- Abort and backpressure:
  - After 2 bytes, abort with in_valid=1 → byte not accepted, IDLE, busy=0. A restart loads correctly from byte 0.
  - in_valid toggling every other cycle yields the same result as nominal.
- Reload preserves old config: after nominal load, load 0x11, 0x22, 0x03, trailer 0x30 → cfg_out stays 20'hF3CA5 until COMMIT, then becomes 20'h32211. start pulsed mid-load is ignored.
- Reset mid-load: rst after byte 1 → cfg_out=0, cfg_valid=0, in_ready=0, IDLE. Padding bits: last byte 0xFF lands as 4'hF in cfg_out[19:16] with no overflow.
